fwd_hazard_unit: RTL

Parametrised forwarding and interlock controller for the LC-3b pipeline. It generalises the per-operand forwarding select to NUM_SRC source operands and NUM_FWD_STAGES producer stages, with youngest-producer priority. It adds the sequential hazard behaviour the pipeline needs: load-use bubble insertion, whole-pipeline freeze on memory-busy, and a freeze watchdog. It sits beside the ID/EX boundary and drives the EX operand muxes and the pipeline-register load enables.

---
 rtl/fwd_hazard_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use bubble and memory-busy freeze control with a freeze watchdog.
// Selects and stalls are combinational; hang_err and counters (FWD_PERF_CNT_EN) are registered.
module fwd_hazard_unit #(
   parameter int NUM_SRC        = 2,
   parameter int NUM_FWD_STAGES = 2,
   parameter int FREEZE_TIMEOUT = 64,
   parameter int SELW           = $clog2(NUM_FWD_STAGES+1)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [NUM_SRC*3-1:0]        src_reg,
   input  logic [NUM_SRC-1:0]          src_used,
   input  logic [NUM_FWD_STAGES-1:0]   stage_regwrite,
   input  logic [NUM_FWD_STAGES*3-1:0] stage_destreg,
   input  logic                        ex_is_load,
   input  logic                        mem_busy,
   output logic [NUM_SRC*SELW-1:0]     fwd_sel,
   output logic                        stall_id,
   output logic                        bubble_ex,
   output logic                        freeze,
   output logic                        hang_err,
   output logic [15:0]                 lu_count,
   output logic [15:0]                 frz_count
);
   localparam int CNTW = ($clog2(FREEZE_TIMEOUT+1) > 8) ? $clog2(FREEZE_TIMEOUT+1) : 8;

   typedef enum logic [1:0] {ST_RUN, ST_BUBBLE, ST_FREEZE} state_t;

   state_t          state_q, state_d;
   logic            lu;
   logic [CNTW-1:0] freeze_cnt_q, freeze_cnt_d;
   logic            hang_err_q, hang_err_d;

   // Scan from the oldest stage down so the youngest matching producer wins.
   always_comb begin
      fwd_sel = '0;
      lu      = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
            if (src_used[i] && stage_regwrite[k-1] &&
                stage_destreg[(k-1)*3 +: 3] == src_reg[i*3 +: 3])
               fwd_sel[i*SELW +: SELW] = SELW'(k);
         end
         if (src_used[i] && stage_regwrite[0] && ex_is_load &&
             stage_destreg[2:0] == src_reg[i*3 +: 3])
            lu = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= ST_RUN;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = ST_RUN;
      case (state_q)
         ST_RUN, ST_BUBBLE, ST_FREEZE: begin
            if (mem_busy) state_d = ST_FREEZE;
            else if (lu)  state_d = ST_BUBBLE;
            else          state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      freeze    = mem_busy;
      stall_id  = lu && !mem_busy;
      bubble_ex = lu && !mem_busy;
   end

   always_comb begin
      if (!mem_busy)             freeze_cnt_d = '0;
      else if (&freeze_cnt_q)    freeze_cnt_d = freeze_cnt_q;
      else                       freeze_cnt_d = freeze_cnt_q + 1'b1;
      // Counter value T-1 during a busy cycle means this edge closes busy cycle T.
      hang_err_d = hang_err_q ||
                   (mem_busy && freeze_cnt_q >= CNTW'(FREEZE_TIMEOUT-1));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         freeze_cnt_q <= '0;
         hang_err_q   <= 1'b0;
      end else begin
         freeze_cnt_q <= freeze_cnt_d;
         hang_err_q   <= hang_err_d;
      end
   end

   assign hang_err = hang_err_q;

`ifdef FWD_PERF_CNT_EN
   logic [15:0] lu_count_q, lu_count_d;
   logic [15:0] frz_count_q, frz_count_d;

   always_comb begin
      lu_count_d  = lu_count_q;
      frz_count_d = frz_count_q;
      if (bubble_ex && !(&lu_count_q))  lu_count_d  = lu_count_q + 16'd1;
      if (freeze && !(&frz_count_q))    frz_count_d = frz_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lu_count_q  <= '0;
         frz_count_q <= '0;
      end else begin
         lu_count_q  <= lu_count_d;
         frz_count_q <= frz_count_d;
      end
   end

   assign lu_count  = lu_count_q;
   assign frz_count = frz_count_q;
`else
   assign lu_count  = '0;
   assign frz_count = '0;
`endif
endmodule
